// File: rtl/jt10_adpcm_kon.sv
// ADPCM-A key/address register sequencer: decodes CPU writes, queues address
// updates and releases key and address events in the target channel's counter slot.
module jt10_adpcm_kon #(
    parameter int FIFO_DW = 2
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        wr,
    input  logic [7:0]  addr,
    input  logic [7:0]  din,
    input  logic [5:0]  cur_ch,
    output logic        aon,
    output logic        aoff,
    output logic [15:0] addr_in,
    output logic [2:0]  addr_ch,
    output logic        up_start,
    output logic        up_end,
    output logic        busy,
    output logic        ovf
);

    localparam int DEPTH = 1 << FIFO_DW;

    logic [5:0]         kon_pend, koff_pend;
    logic [5:0]         kon_next, koff_next;
    logic [7:0]         start_lsb [0:5];
    logic [7:0]         end_lsb   [0:5];

    logic               fifo_type [0:DEPTH-1];
    logic [2:0]         fifo_ch   [0:DEPTH-1];
    logic [15:0]        fifo_val  [0:DEPTH-1];
    logic [FIFO_DW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_DW:0]   count;

    logic               head_valid, pop, push_ok, full;
    logic [5:0]         head_hot, blk, iss_on, iss_off;
    logic [4:0]         grp;
    logic [2:0]         chn;
    logic               ch_ok, wr_key, wr_slsb, wr_smsb, wr_elsb, wr_emsb, commit;
    logic [15:0]        commit_val;

    // Register decode
    always_comb begin
        grp        = addr[7:3];
        chn        = addr[2:0];
        ch_ok      = chn < 3'd6;
        wr_key     = wr && (addr == 8'h00);
        wr_slsb    = wr && ch_ok && (grp == 5'h02);
        wr_smsb    = wr && ch_ok && (grp == 5'h03);
        wr_elsb    = wr && ch_ok && (grp == 5'h04);
        wr_emsb    = wr && ch_ok && (grp == 5'h05);
        commit     = wr_smsb || wr_emsb;
        commit_val = '0;
        if (ch_ok)
            commit_val = {din, wr_emsb ? end_lsb[chn] : start_lsb[chn]};
    end

    // FIFO head, pop and per-channel blocking of key-on
    always_comb begin
        logic [FIFO_DW-1:0] idx;
        head_valid = count != '0;
        full       = count == (FIFO_DW+1)'(DEPTH);
        head_hot   = 6'b000001 << fifo_ch[rd_ptr];
        pop        = cen && head_valid && (cur_ch == head_hot);
        push_ok    = commit && (!full || pop);
        blk        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + i[FIFO_DW-1:0];
            if (i < 32'(count) && !(i == 0 && pop)) begin
                for (int unsigned n = 0; n < 6; n++)
                    if (fifo_ch[idx] == n[2:0]) blk[n] = 1'b1;
            end
        end
    end

    // Clear what this slot issues, then apply a same-cycle key write on top
    always_comb begin
        iss_on    = cen ? (kon_pend & cur_ch & ~blk) : '0;
        iss_off   = cen ? (koff_pend & cur_ch) : '0;
        kon_next  = kon_pend & ~iss_on;
        koff_next = koff_pend & ~iss_off;
        if (wr_key) begin
            if (din[7]) begin
                koff_next = koff_next | din[5:0];
                kon_next  = kon_next & ~din[5:0];
            end else begin
                kon_next  = kon_next | din[5:0];
                koff_next = koff_next & ~din[5:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kon_pend  <= '0;
            koff_pend <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            for (int unsigned n = 0; n < 6; n++) begin
                start_lsb[n] <= '0;
                end_lsb[n]   <= '0;
            end
        end else begin
            kon_pend  <= kon_next;
            koff_pend <= koff_next;
            if (wr_slsb) start_lsb[chn] <= din;
            if (wr_elsb) end_lsb[chn]   <= din;
            if (commit && full && !pop) ovf <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is qualified by count, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_type[wr_ptr] <= wr_emsb;
            fifo_ch[wr_ptr]   <= chn;
            fifo_val[wr_ptr]  <= commit_val;
        end
    end

    always_comb begin
        aon      = |(kon_pend & cur_ch & ~blk);
        aoff     = |(koff_pend & cur_ch);
        addr_ch  = head_valid ? fifo_ch[rd_ptr] : 3'd7;
        addr_in  = head_valid ? fifo_val[rd_ptr] : '0;
        up_start = head_valid && !fifo_type[rd_ptr];
        up_end   = head_valid && fifo_type[rd_ptr];
        busy     = head_valid || (|kon_pend) || (|koff_pend);
    end

endmodule
